// File: rtl/router_pkg.sv
// router_pkg: shared widths, invalid address constant and FSM state encoding
// for the 1x3 router (used by router_fsm, router_reg and router_parity_chk).
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    // All-ones address selects no FIFO and is rejected at decode.
    localparam logic [ADDR_W_DEF-1:0] INVALID_ADDR = '1;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

endpackage

// File: rtl/router_parity_chk.sv
// router_parity_chk: running XOR parity, trailing parity capture, error flag.
// Optional ROUTER_REG_ERR_CNT_EN adds a saturating count of error events.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              detect_add_i,
    input  logic              lfd_state_i,
    input  logic              ld_state_i,
    input  logic              laf_state_i,
    input  logic              full_state_i,
    input  logic              fifo_full_i,
    input  logic              pkt_valid_i,
    input  logic              low_pkt_valid_i,
    input  logic              rst_int_reg_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [DATA_W-1:0] header_i,
    input  logic [DATA_W-1:0] hold_byte_i,
    output logic              parity_done_o,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]        err_cnt_o,
`endif
    output logic              err_o
);

    logic [DATA_W-1:0] int_par_q, int_par_d;
    logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cap_ld, cap_laf;

    // Parity byte arrives directly in LOAD_DATA, or from the hold byte
    // when it was refused because the FIFO was full.
    assign cap_ld  = ld_state_i && !pkt_valid_i && !fifo_full_i;
    assign cap_laf = laf_state_i && low_pkt_valid_i;

    // Next-state for parity accumulation, capture and error flag.
    always_comb begin
        int_par_d = int_par_q;
        pkt_par_d = pkt_par_q;
        done_d    = done_q;
        err_d     = err_q;

        if (detect_add_i) begin
            int_par_d = '0;
        end else if (lfd_state_i) begin
            int_par_d = int_par_q ^ header_i;
        end else if (ld_state_i && pkt_valid_i && !full_state_i && !fifo_full_i) begin
            int_par_d = int_par_q ^ data_in_i;
        end else if (laf_state_i && !low_pkt_valid_i) begin
            int_par_d = int_par_q ^ hold_byte_i;
        end

        if (detect_add_i) begin
            pkt_par_d = '0;
            done_d    = 1'b0;
        end else if (cap_ld) begin
            pkt_par_d = data_in_i;
            done_d    = 1'b1;
        end else if (cap_laf) begin
            pkt_par_d = hold_byte_i;
            done_d    = 1'b1;
        end

        if (rst_int_reg_i && done_q) begin
            err_d = (int_par_q != pkt_par_q);
        end else if (lfd_state_i) begin
            err_d = 1'b0;
        end
    end

    // Parity state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            int_par_q <= '0;
            pkt_par_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            int_par_q <= int_par_d;
            pkt_par_q <= pkt_par_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Count each rising edge of err, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (err_d && !err_q && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Error counter register; only resetn clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt_o = cnt_q;
`endif

    assign parity_done_o = done_q;
    assign err_o         = err_q;

endmodule

// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router (header, dout, hold byte).
// Define ROUTER_REG_ERR_CNT_EN to add the err_cnt output.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              err
);

    logic [DATA_W-1:0] header_q, header_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              low_q, low_d;
    logic              addr_ok;

    assign addr_ok = (data_in[ADDR_W-1:0] != {ADDR_W{1'b1}});

    // Header latch, FIFO write-byte mux, hold byte and late-end flag.
    always_comb begin
        header_d = header_q;
        hold_d   = hold_q;
        dout_d   = dout_q;
        low_d    = low_q;

        if (detect_add && pkt_valid && addr_ok) begin
            header_d = data_in;
        end

        if (lfd_state) begin
            dout_d = header_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state) begin
            hold_d = data_in;
        end else if (laf_state) begin
            dout_d = hold_q;
        end

        if (rst_int_reg) begin
            low_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_d = 1'b1;
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            header_q <= '0;
            hold_q   <= '0;
            dout_q   <= '0;
            low_q    <= 1'b0;
        end else begin
            header_q <= header_d;
            hold_q   <= hold_d;
            dout_q   <= dout_d;
            low_q    <= low_d;
        end
    end

    router_parity_chk #(
        .DATA_W (DATA_W)
    ) u_par (
        .clk             (clk),
        .resetn          (resetn),
        .detect_add_i    (detect_add),
        .lfd_state_i     (lfd_state),
        .ld_state_i      (ld_state),
        .laf_state_i     (laf_state),
        .full_state_i    (full_state),
        .fifo_full_i     (fifo_full),
        .pkt_valid_i     (pkt_valid),
        .low_pkt_valid_i (low_q),
        .rst_int_reg_i   (rst_int_reg),
        .data_in_i       (data_in),
        .header_i        (header_q),
        .hold_byte_i     (hold_q),
        .parity_done_o   (parity_done),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_cnt_o       (err_cnt),
`endif
        .err_o           (err)
    );

    assign dout          = dout_q;
    assign low_pkt_valid = low_q;

endmodule
